// File: rtl/fwd_sel_unit.sv
// Operand-forwarding select and load-use stall controller for the femtoRV32 pipeline.
// Tracks rd metadata through EX, MEM, WB and a post-WB slot, and decodes the ALU mux selects.
module fwd_sel_unit #(
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_regwrite,
  input  logic             id_memread,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall
);

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10,
    SEL_HOLD  = 2'b11
  } sel_e;

  logic             ex_valid, ex_regwrite, ex_memread, ex_use_rs1, ex_use_rs2;
  logic [REG_W-1:0] ex_rd, ex_rs1, ex_rs2;
  logic             mem_valid, mem_regwrite, mem_memread;
  logic [REG_W-1:0] mem_rd;
  logic             wb_valid, wb_regwrite;
  logic [REG_W-1:0] wb_rd;
  logic             hw_valid, hw_regwrite;
  logic [REG_W-1:0] hw_rd;

  logic mem_wr, wb_wr, hw_wr;
  sel_e sel_a, sel_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_use_rs1   <= 1'b0;
      ex_use_rs2   <= 1'b0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_rd        <= '0;
      hw_valid     <= 1'b0;
      hw_regwrite  <= 1'b0;
      hw_rd        <= '0;
    end else if (!hold) begin
      hw_valid     <= wb_valid;
      hw_regwrite  <= wb_regwrite;
      hw_rd        <= wb_rd;
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_rd        <= mem_rd;
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      mem_rd       <= ex_rd;
      // stall already excludes flush; both turn the incoming slot into a bubble
      ex_valid     <= id_valid & ~stall & ~flush;
      ex_regwrite  <= id_regwrite;
      ex_memread   <= id_memread;
      ex_use_rs1   <= id_use_rs1;
      ex_use_rs2   <= id_use_rs2;
      ex_rd        <= id_rd;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
    end
  end

  assign mem_wr = mem_valid & mem_regwrite & (mem_rd != '0);
  assign wb_wr  = wb_valid  & wb_regwrite  & (wb_rd  != '0);
  assign hw_wr  = hw_valid  & hw_regwrite  & (hw_rd  != '0);

  // Youngest producer wins; rd != 0 in each *_wr makes an x0 source fall through to the register file.
  function automatic sel_e pick(input logic en, input logic [REG_W-1:0] rs,
                                input logic m_wr, input logic [REG_W-1:0] m_rd,
                                input logic w_wr, input logic [REG_W-1:0] w_rd,
                                input logic h_wr, input logic [REG_W-1:0] h_rd);
    sel_e s;
    s = SEL_RF;
    if (en) begin
      if (m_wr && m_rd == rs)      s = SEL_EXMEM;
      else if (w_wr && w_rd == rs) s = SEL_MEMWB;
      else if (h_wr && h_rd == rs) s = SEL_HOLD;
    end
    return s;
  endfunction

  always_comb begin
    sel_a = pick(ex_valid & ex_use_rs1, ex_rs1, mem_wr, mem_rd, wb_wr, wb_rd, hw_wr, hw_rd);
    sel_b = pick(ex_valid & ex_use_rs2, ex_rs2, mem_wr, mem_rd, wb_wr, wb_rd, hw_wr, hw_rd);
  end

  assign fwd_a_sel = sel_a;
  assign fwd_b_sel = sel_b;

  assign stall = ~hold & ~flush & id_valid & ex_valid & ex_memread & ex_regwrite & (ex_rd != '0)
               & ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // A load in MEM must never be the forwarding source: the stall keeps its consumer out of EX.
  ld_no_exmem_fwd: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_memread && (sel_a == SEL_EXMEM || sel_b == SEL_EXMEM)));

endmodule
